// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e        : controller FSM states (run, waiting on dmem, halted by watchdog)
//   FWD_*          : operand forward-select encodings driven to the EX-stage muxes
//   BR_STAGE_*     : legal values of the BRANCH_STAGE parameter
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StHalt    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned BR_STAGE_EX  = 0;
  localparam int unsigned BR_STAGE_MEM = 1;

endpackage

// File: rtl/fwd_sel.sv
// Forward select for one EX-stage source operand.
// Ports:
//   i_ex_rs          source register of the instruction in EX
//   i_mem_rd/_write  destination and write flag of the instruction in MEM
//   i_wb_rd/_write   destination and write flag of the instruction in WB
//   o_fwd            FWD_MEM, FWD_WB or FWD_RF; the younger (MEM) result wins, x0 never forwards
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  output logic [1:0]            o_fwd
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_mem_hit) begin
      o_fwd = FWD_MEM;
    end else if (w_wb_hit) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Centralised hazard controller for the 5-stage RV64 pipeline.
// Produces operand forward selects, load-use bubbles, taken-branch flushes and a whole-pipe
// freeze while data memory is busy; a watchdog halts the core if memory never answers.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-low reset
//   i_id_* / i_ex_* / i_mem_* / i_wb_*  register indices and write flags per stage
//   i_br_taken                    taken branch resolved at BRANCH_STAGE
//   i_dmem_req, i_dmem_ready      MEM-stage access handshake
//   o_forward_a/_b                operand forward selects
//   o_pc_write, o_ifid_write, o_pipe_write   register enables
//   o_ifid_flush, o_idex_flush, o_exmem_flush  bubble/zero controls
//   o_halted                      sticky watchdog halt
//   o_stall_cnt/_flush_cnt/_wait_cnt  saturating perf counters
// Build option: define PIPE_PERF_CNT_EN to build the perf counters; otherwise they read 0.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned BRANCH_STAGE = 0,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  input  logic                  i_br_taken,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ready,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_pipe_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_flush,
  output logic                  o_exmem_flush,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt,
  output logic [CNT_W-1:0]      o_wait_cnt
);

  // The wait counter holds the length of the current wait episode, including the RUN cycle
  // that started it, so it never needs to exceed MEM_TIMEOUT-1.
  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WaitW-1:0] r_wait_ctr;
  logic [WaitW-1:0] w_wait_next;
  logic             r_halted;

  logic w_dmem_stall;
  logic w_freeze;
  logic w_load_use;

  fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .i_ex_rs        (i_ex_rs1),
    .i_mem_rd       (i_mem_rd),
    .i_mem_reg_write(i_mem_reg_write),
    .i_wb_rd        (i_wb_rd),
    .i_wb_reg_write (i_wb_reg_write),
    .o_fwd          (o_forward_a)
  );

  fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .i_ex_rs        (i_ex_rs2),
    .i_mem_rd       (i_mem_rd),
    .i_mem_reg_write(i_mem_reg_write),
    .i_wb_rd        (i_wb_rd),
    .i_wb_reg_write (i_wb_reg_write),
    .o_fwd          (o_forward_b)
  );

  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs1) || (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));

  assign w_dmem_stall = i_dmem_req && !i_dmem_ready;
  // Combinational so the stall takes effect in the very cycle memory is not ready.
  assign w_freeze = (r_state == StHalt) ||
                    (((r_state == StRun) || (r_state == StMemWait)) && w_dmem_stall);

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_ctr;
    case (r_state)
      StRun: begin
        if (w_dmem_stall) begin
          w_state_next = StMemWait;
          w_wait_next  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (i_dmem_ready) begin
          w_state_next = StRun;
        end else if (w_dmem_stall) begin
          if (r_wait_ctr >= WaitLast) begin
            w_state_next = StHalt;
          end else begin
            w_wait_next = r_wait_ctr + WaitW'(1);
          end
        end
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StRun;
      r_wait_ctr <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_ctr <= w_wait_next;
      r_halted   <= (w_state_next == StHalt);
    end
  end

  assign o_halted = r_halted;

  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_pipe_write  = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    if (!i_rst) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_pipe_write  = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (w_freeze) begin
      // Everything holds; a pending branch or load-use is still presented once freeze drops.
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_pipe_write = 1'b0;
    end else if (i_br_taken) begin
      // The wrong-path instruction in EX is only younger than the branch when it resolves in MEM.
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = (BRANCH_STAGE == BR_STAGE_MEM);
    end else if (w_load_use) begin
      // Hold PC and IF/ID, let the load advance and insert one bubble behind it.
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic             w_wait_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  assign w_stall_evt = !w_freeze && !i_br_taken && w_load_use;
  assign w_flush_evt = !w_freeze && i_br_taken;
  assign w_wait_evt  = w_freeze && (r_state != StHalt);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_wait_evt && (r_wait_cnt != '1))   r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_wait_cnt  = r_wait_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
  assign o_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BRANCH_STAGE = MEM, MEM_TIMEOUT = 4).
// Each step drives inputs at the falling edge, pushes the expected outputs to a scoreboard,
// then pops and compares shortly afterwards, well away from the rising edge.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // {pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, exmem_flush}
  localparam logic [5:0] CtlNorm = 6'b111_000;
  localparam logic [5:0] CtlRst  = 6'b000_111;
  localparam logic [5:0] CtlFrz  = 6'b000_000;
  localparam logic [5:0] CtlBr   = 6'b111_111;
  localparam logic [5:0] CtlLu   = 6'b001_010;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       br_taken, dmem_req, dmem_ready;
  logic [1:0] forward_a, forward_b;
  logic       pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, exmem_flush, halted;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .BRANCH_STAGE(1),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_uses_rs2  (id_uses_rs2),
    .i_ex_rs1       (ex_rs1),
    .i_ex_rs2       (ex_rs2),
    .i_ex_rd        (ex_rd),
    .i_ex_mem_read  (ex_mem_read),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .i_br_taken     (br_taken),
    .i_dmem_req     (dmem_req),
    .i_dmem_ready   (dmem_ready),
    .o_forward_a    (forward_a),
    .o_forward_b    (forward_b),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_pipe_write   (pipe_write),
    .o_ifid_flush   (ifid_flush),
    .o_idex_flush   (idex_flush),
    .o_exmem_flush  (exmem_flush),
    .o_halted       (halted),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt),
    .o_wait_cnt     (wait_cnt)
  );

  typedef struct {
    string       tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [5:0]  ctl;
    logic        hlt;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] waitc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic [31:0] m_wait  = '0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // s/f/w: whether this cycle is a load-use stall, branch flush, or non-halt wait event;
  // the counters show it from the next cycle on.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [5:0] ctl, input logic hlt,
                      input bit s, input bit f, input bit w);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.hlt = hlt;
    e.stall = m_stall; e.flush = m_flush; e.waitc = m_wait;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    cmp({e.tag, ".fwd_a"}, 32'(forward_a), 32'(e.fa));
    cmp({e.tag, ".fwd_b"}, 32'(forward_b), 32'(e.fb));
    cmp({e.tag, ".ctl"},
        32'({pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, exmem_flush}),
        32'(e.ctl));
    cmp({e.tag, ".halted"}, 32'(halted), 32'(e.hlt));
    cmp({e.tag, ".stall_cnt"}, stall_cnt, e.stall);
    cmp({e.tag, ".flush_cnt"}, flush_cnt, e.flush);
    cmp({e.tag, ".wait_cnt"}, wait_cnt, e.waitc);
    if (PerfEn) begin
      if (s) m_stall++;
      if (f) m_flush++;
      if (w) m_wait++;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    br_taken = 1'b1;
    @(negedge clk);
    step("reset_br", 2'b00, 2'b00, CtlRst, 1'b0, 0, 0, 0);

    @(negedge clk); idle_inputs();
    step("run_idle", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk);
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    step("fwd_mem_prio", 2'b10, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); mem_reg_write = 0;
    step("fwd_wb", 2'b01, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk);
    ex_rs1 = 0; mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
    step("fwd_x0", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk);
    ex_rs1 = 3; ex_rs2 = 9; mem_rd = 9; wb_rd = 9;
    step("fwd_b_mem", 2'b00, 2'b10, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); idle_inputs();
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
    step("load_use_rs2", 2'b00, 2'b00, CtlLu, 1'b0, 1, 0, 0);

    @(negedge clk); ex_mem_read = 0; ex_rd = 0;
    step("after_bubble", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); ex_mem_read = 1; ex_rd = 7; id_uses_rs2 = 0;
    step("rs2_unused", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); ex_rd = 0; id_rs1 = 0;
    step("load_x0", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); ex_rd = 4; id_rs1 = 4;
    step("load_use_rs1", 2'b00, 2'b00, CtlLu, 1'b0, 1, 0, 0);

    @(negedge clk); br_taken = 1;
    step("br_over_lu", 2'b00, 2'b00, CtlBr, 1'b0, 0, 1, 0);

    @(negedge clk); idle_inputs();
    step("post_branch", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); dmem_req = 1; dmem_ready = 0;
    step("wait1", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk); br_taken = 1;
    step("wait2_br_held", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk); br_taken = 0;
    step("wait3", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk); dmem_ready = 1;
    step("wait_done", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);
    @(negedge clk); idle_inputs();
    step("run_again", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); dmem_req = 1; dmem_ready = 0;
    step("to_1", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("to_2", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("to_3", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("to_4", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("halt_frozen", 2'b00, 2'b00, CtlFrz, 1'b1, 0, 0, 0);
    @(negedge clk); dmem_req = 0; dmem_ready = 1; br_taken = 1;
    step("halt_sticky", 2'b00, 2'b00, CtlFrz, 1'b1, 0, 0, 0);

    @(negedge clk); rst = 0;
    step("halt_reset", 2'b00, 2'b00, CtlRst, 1'b1, 0, 0, 0);
    m_stall = '0; m_flush = '0; m_wait = '0;
    @(negedge clk); idle_inputs();
    step("run_after_halt", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); dmem_req = 1; dmem_ready = 0;
    step("mw_enter", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("mw_second", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk); rst = 0;
    step("mw_reset", 2'b00, 2'b00, CtlRst, 1'b0, 0, 0, 0);
    m_stall = '0; m_flush = '0; m_wait = '0;
    @(negedge clk); idle_inputs();
    step("mw_reset_run", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);
    // A fresh episode must again take four wait cycles before halting.
    @(negedge clk); dmem_req = 1; dmem_ready = 0;
    step("fresh_1", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("fresh_2", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk);
    step("fresh_3", 2'b00, 2'b00, CtlFrz, 1'b0, 0, 0, 1);
    @(negedge clk); dmem_ready = 1;
    step("fresh_done", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    @(negedge clk); idle_inputs();
    step("final", 2'b00, 2'b00, CtlNorm, 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Centralised hazard controller for the 5-stage RV64 pipeline. It succeeds the standalone forwarding unit.
- Generates EX/MEM and MEM/WB forwarding selects, load-use bubbles, and taken-branch flushes at a configurable resolve stage.
- Freezes the whole pipeline while data memory is not ready, with a timeout watchdog that halts the core.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write/flush enables.

Parameters:
REG_ADDR_W, 5, register index width
BRANCH_STAGE, 0, branch resolve stage: 0 = EX, 1 = MEM
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before halt (≥1)
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
id_rs1  in  REG_ADDR_W  decode rs1
id_rs2  in  REG_ADDR_W  decode rs2
id_uses_rs2  in  1  decode instr reads rs2
ex_rs1  in  REG_ADDR_W  ID/EX rs1
ex_rs2  in  REG_ADDR_W  ID/EX rs2
ex_rd  in  REG_ADDR_W  ID/EX rd
ex_mem_read  in  1  ID/EX is load
mem_rd  in  REG_ADDR_W  EX/MEM rd
mem_reg_write  in  1  EX/MEM writes rd
wb_rd  in  REG_ADDR_W  MEM/WB rd
wb_reg_write  in  1  MEM/WB writes rd
br_taken  in  1  taken branch at BRANCH_STAGE
dmem_req  in  1  MEM stage access active
dmem_ready  in  1  data memory completes this cycle
forward_a  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB
forward_b  out  2  same encoding for rs2
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID enable
pipe_write  out  1  ID/EX, EX/MEM, MEM/WB enable
ifid_flush  out  1  zero IF/ID
idex_flush  out  1  bubble into ID/EX
exmem_flush  out  1  bubble into EX/MEM
halted  out  1  watchdog halt, sticky
stall_cnt  out  CNT_W  perf: load-use stall cycles
flush_cnt  out  CNT_W  perf: branch flush events
wait_cnt  out  CNT_W  perf: dmem wait cycles

Behaviour:
- Forwarding, combinational, per operand:
  - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rsX.
  - Else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rsX.
  - Else 00. EX/MEM has priority. x0 never forwarded.
- load_use = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
- FSM states: RUN, MEM_WAIT, HALT; 2-bit state register.
  - RUN → MEM_WAIT when dmem_req && !dmem_ready.
  - MEM_WAIT → RUN when dmem_ready.
  - MEM_WAIT → HALT when the wait counter reaches MEM_TIMEOUT.
  - HALT is terminal until reset.
  - Wait counter clears on entry to MEM_WAIT.
- Freeze = HALT, or (RUN or MEM_WAIT) && dmem_req && !dmem_ready. Freeze is combinational, so a stall starts in the same cycle.
- Control-output priority, highest first:
  1. rst low: all write enables 0, all flushes 1.
  2. Freeze: pc_write = ifid_write = pipe_write = 0, all flushes 0. Held br_taken/load_use are acted on once freeze drops.
  3. br_taken: pc_write = 1, ifid_flush = 1, idex_flush = 1, exmem_flush = BRANCH_STAGE. load_use is ignored.
  4. load_use: pc_write = 0, ifid_write = 0, idex_flush = 1, pipe_write = 1. Exactly one bubble per hazard.
  5. Otherwise all enables 1, flushes 0.
- Reset (rst low at posedge): state = RUN, wait counter = 0, halted = 0, perf counters = 0.
- halted = (state == HALT), registered.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid MEM_WAIT or HALT returns to RUN on the next edge.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: stall_cnt increments on each cycle with priority-4 action; flush_cnt increments on each priority-3 cycle; wait_cnt increments on each frozen non-HALT cycle. All saturating.
- Undefined: counter registers are not built; the three ports are tied to 0.

Decomposition:
- Package pipe_ctrl_pkg:
  - State enum (RUN, MEM_WAIT, HALT).
  - Forward encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Branch-stage constants.
- Sub-module fwd_sel: one operand's forward select, instantiated twice (rs1, rs2).

Test Plan:
- EX/MEM vs MEM/WB priority: ex_rs1=5, mem_rd=5/mem_reg_write=1, wb_rd=5/wb_reg_write=1 → forward_a=10. Drop mem_reg_write → 01. mem_rd=0 with ex_rs1=0 → 00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_uses_rs2=1 → one cycle with pc_write=0, ifid_write=0, idex_flush=1. Next cycle (load moved on) → normal.
- Branch vs load-use: br_taken=1 together with load_use, BRANCH_STAGE=1 → pc_write=1, ifid/idex/exmem_flush=1, stall_cnt unchanged, flush_cnt +1.
- Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 → pc_write/ifid_write/pipe_write=0 for 3 cycles, state MEM_WAIT, wait_cnt=3, RUN after.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → halted=1 after the 4th wait cycle, stays frozen. rst low one edge → halted=0, state RUN.
- Reset: rst low with br_taken=1 → all write enables 0, flushes 1, counters 0 after the edge.
